// File: rtl/sfp_pkg.sv
// Shared definitions for the special-function / partial-sum bank:
// saturation limits, the saturating adder and the lane slice helper.
package sfp_pkg;

    // Result of a saturating add: clamped value plus a flag saying a clamp happened.
    typedef struct packed {
        logic signed [63:0] value;
        logic               clamped;
    } sat_res_t;

    // Largest representable signed value for a psum of width bw.
    function automatic logic signed [63:0] psum_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    // Smallest representable signed value for a psum of width bw.
    function automatic logic signed [63:0] psum_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

    // Operands arrive sign-extended to 64 bits, so the sum cannot wrap for
    // any practical bw; it behaves exactly like a bw+1 bit sum followed by a clamp.
    function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                         input logic signed [63:0] b,
                                         input int                 bw);
        sat_res_t           r;
        logic signed [63:0] sum;
        sum       = a + b;
        r.clamped = 1'b1;
        if (sum > psum_max(bw)) begin
            r.value = psum_max(bw);
        end else if (sum < psum_min(bw)) begin
            r.value = psum_min(bw);
        end else begin
            r.value   = sum;
            r.clamped = 1'b0;
        end
        return r;
    endfunction

    // Bit offset of a lane inside a packed multi-lane word.
    function automatic int lane_lsb(input int lane, input int bw);
        return lane * bw;
    endfunction

endpackage

// File: rtl/sfp_lane.sv
// One lane of the bank: overwrite / saturating-accumulate mux on the write
// side, and the optional ReLU clamp on the read side. Purely combinational.
module sfp_lane
    import sfp_pkg::*;
#(
    parameter int psum_bw = 16
) (
    input  logic               overwrite,
    input  logic [psum_bw-1:0] old_val,
    input  logic [psum_bw-1:0] add_val,
    output logic [psum_bw-1:0] new_val,
    output logic               sat,
    input  logic               relu,
    input  logic [psum_bw-1:0] rd_val,
    output logic [psum_bw-1:0] rd_out
);

    sat_res_t sum_res;

    // Write path: either take the incoming psum or add it to the stored one with clamping.
    always_comb begin
        sum_res = sat_add(64'($signed(old_val)), 64'($signed(add_val)), psum_bw);
        new_val = overwrite ? add_val : psum_bw'(sum_res.value);
        // A clamp only counts when an add actually happened.
        sat     = ~overwrite & sum_res.clamped;
    end

    // Read path: ReLU zeroes negative values, positive values pass through untouched.
    always_comb begin
        rd_out = (relu && rd_val[psum_bw-1]) ? '0 : rd_val;
    end

endmodule

// File: rtl/sfp_bank.sv
// Multi-lane partial-sum accumulation bank with saturating add, ReLU on
// readout, clear-on-read and sticky per-lane saturation flags.
module sfp_bank
    import sfp_pkg::*;
#(
    parameter  int psum_bw = 16,
    parameter  int col     = 8,
    parameter  int depth   = 16,
    localparam int aw      = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   acc_valid,
    input  logic                   acc_first,
    input  logic [aw-1:0]          acc_addr,
    input  logic [col*psum_bw-1:0] acc_data,
    input  logic                   rd_en,
    input  logic [aw-1:0]          rd_addr,
    input  logic                   rd_clear,
    input  logic                   relu,
    output logic                   out_valid,
    output logic [col*psum_bw-1:0] out_data,
    output logic [col-1:0]         sat_flag,
    input  logic                   sat_clr
);

    // Entry storage; contents are meaningless unless the matching valid bit is set.
    logic [col*psum_bw-1:0] mem_q [depth];
    logic [depth-1:0]       valid_q, valid_d;
    logic                   out_valid_q, out_valid_d;
    logic [col*psum_bw-1:0] out_data_q, out_data_d;
    logic [col-1:0]         sat_q, sat_d;

    logic [col*psum_bw-1:0] acc_old, acc_new, rd_word, rd_relu;
    logic [col-1:0]         lane_sat;
    logic                   overwrite;

    // Fetch the entries addressed by the accumulate and read ports (pre-update values).
    always_comb begin
        acc_old   = mem_q[acc_addr];
        overwrite = acc_first | ~valid_q[acc_addr];
        rd_word   = valid_q[rd_addr] ? mem_q[rd_addr] : '0;
    end

    genvar gi;
    generate
        for (gi = 0; gi < col; gi++) begin : g_lane
            sfp_lane #(
                .psum_bw (psum_bw)
            ) u_lane (
                .overwrite (overwrite),
                .old_val   (acc_old[lane_lsb(gi, psum_bw) +: psum_bw]),
                .add_val   (acc_data[lane_lsb(gi, psum_bw) +: psum_bw]),
                .new_val   (acc_new[lane_lsb(gi, psum_bw) +: psum_bw]),
                .sat       (lane_sat[gi]),
                .relu      (relu),
                .rd_val    (rd_word[lane_lsb(gi, psum_bw) +: psum_bw]),
                .rd_out    (rd_relu[lane_lsb(gi, psum_bw) +: psum_bw])
            );
        end
    endgenerate

    // Next-state for valid bits, read output and sticky flags.
    always_comb begin
        valid_d = valid_q;
        // Clear first so an accumulate to the same entry ends up valid.
        if (rd_en && rd_clear) begin
            valid_d[rd_addr] = 1'b0;
        end
        if (acc_valid) begin
            valid_d[acc_addr] = 1'b1;
        end

        out_valid_d = rd_en;
        out_data_d  = rd_en ? rd_relu : out_data_q;

        // A fresh saturation overrides a simultaneous clear.
        sat_d = sat_q;
        if (sat_clr) begin
            sat_d = '0;
        end
        if (acc_valid) begin
            sat_d = sat_d | lane_sat;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sat_q       <= sat_d;
        end
    end

    // Entry storage write; no reset since the valid vector masks stale data.
    always_ff @(posedge clk) begin
        if (acc_valid) begin
            mem_q[acc_addr] <= acc_new;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat_flag  = sat_q;

endmodule

// File: doc/sfp_bank.md
# sfp_bank

Parametrised special-function / partial-sum accumulation stage for the corelet output path. Replaces the per-column single-register SFP with `col` lanes that share a `depth`-entry accumulation buffer, so several output pixels can accumulate in parallel across kernel passes. Sits between the OFIFO drain and the SRAM write-back. Adds signed saturating accumulation, an optional ReLU applied on readout, and clear-on-read.

## Interface
- `psum_bw`, 16: signed partial-sum width per lane
- `col`, 8: number of lanes (channels)
- `depth`, 16: accumulation entries; power of two, ≥2
- `aw`, $clog2(depth): address width (derived, not overridable)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `acc_valid`  in  1  accumulate request this cycle
- `acc_first`  in  1  with `acc_valid`: overwrite entry instead of adding (first kernel pass)
- `acc_addr`  in  aw  entry to accumulate into
- `acc_data`  in  col*psum_bw  lane i at bits [psum_bw*(i+1)-1 : psum_bw*i], signed
- `rd_en`  in  1  read request
- `rd_addr`  in  aw  entry to read
- `rd_clear`  in  1  with `rd_en`: invalidate the entry after reading
- `relu`  in  1  sampled with `rd_en`: clamp negative lanes to 0 on output
- `out_valid`  out  1  `out_data` valid
- `out_data`  out  col*psum_bw  readout, same lane packing
- `sat_flag`  out  col  sticky per-lane saturation indicator
- `sat_clr`  in  1  clears `sat_flag`

## Operation
- Storage: `depth` × `col` × `psum_bw` register array, plus a `depth`-bit valid vector.
- Accumulate, on `acc_valid`:
  - `acc_first`=1, or entry invalid: entry ← `acc_data`; valid ← 1.
  - Otherwise: entry ← sat(entry + `acc_data`) per lane, where sat clamps to [−2^(psum_bw−1), 2^(psum_bw−1)−1]. Overflow computed on a psum_bw+1 sum.
  - Any clamp sets that lane's `sat_flag` bit.
- Read, on `rd_en`:
  - Output is the entry, or all-zero if the entry is invalid.
  - `relu`=1 replaces negative lanes with 0. Stored value is unchanged.
  - `rd_clear`=1 sets the entry's valid bit to 0. Data is not zeroed.
- Same cycle, same address for `acc_valid` and `rd_en`:
  - Read returns the pre-update value.
  - Accumulate proceeds.
  - If `rd_clear` is also set, the accumulate wins: valid ends at 1 and the entry holds the accumulate result, computed against the old entry.
- Different addresses proceed independently, both in one cycle.
- `sat_clr` together with a new saturation: the set wins.
- Reset clears the valid vector, `out_valid`, `out_data`, and `sat_flag`. Array contents are don't-care after reset.

## Timing
- Accumulate: the write commits at the rising edge where `acc_valid`=1. A read in the following cycle sees the new value; no bubble is required between back-to-back accumulates to the same address.
- Read latency is 1 cycle. `out_valid` and `out_data` are registered and follow the `rd_en` cycle.
- `out_valid` is high for exactly one cycle per `rd_en`.
- `out_data` holds its last value when `out_valid`=0.
- Throughput: one accumulate plus one read per cycle, no backpressure.
- Reset asserted mid-stream: outputs go to 0 immediately (asynchronous). The first request after deassertion is honoured on the next edge.
- All outputs reset to 0.

## Structure
- Shared package `sfp_pkg`:
  - `PSUM_MAX`/`PSUM_MIN` as functions of `psum_bw`
  - `sat_add` function
  - lane slice macro/function
- Sub-module `sfp_lane`: one lane's saturating add / overwrite mux, plus the ReLU output mux. Instantiated `col` times in a generate loop.
- Address decode, valid vector, and output registers stay in `sfp_bank`.

## Test plan
- Reset, then `rd_en` at addr 3 → `out_valid`=1 next cycle, `out_data`=0.
- Accumulate addr 5 with `acc_first`, lane0=100; accumulate lane0=−30; read → lane0=70. Read with `relu`=1 after adding −200 → lane0=0 while the stored value stays −130.
- Lane0 at 32760, add 100 with psum_bw=16 → stored 32767, `sat_flag[0]`=1. Negative side: −32760 + (−100) → −32768. `sat_clr` → flag 0.
- Same cycle: `acc_valid` and `rd_en`+`rd_clear` at addr 2 holding 10, adding 5 → `out_data` lane=10; next read → 15, entry still valid.
- Read addr 7 with `rd_clear`, then accumulate 4 without `acc_first` → next read returns 4, not old+4.
- `col`=4, `depth`=4, back-to-back accumulates across all addresses at full rate, interleaved reads, `reset` asserted mid-burst → scoreboard matches; after reset every read returns 0.
